// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the data memory.
// Port 0 is the core LSU, port 1 the debug/DMA loader; one access is in flight at a time.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2:0]            funct3_0,
    input  logic [2:0]            funct3_1,
    input  logic [DM_ADDRESS-1:0] addr_0,
    input  logic [DM_ADDRESS-1:0] addr_1,
    input  logic [DATA_W-1:0]     wdata_0,
    input  logic [DATA_W-1:0]     wdata_1,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [2:0]            mem_funct3,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;
    state_t                state;
    logic                  last_winner;
    logic                  owner;
    logic                  win;
    logic                  legal;
    logic                  l_we;
    logic [2:0]            l_f3;
    logic [DM_ADDRESS-1:0] l_addr;
    logic [DATA_W-1:0]     l_wdata;
    logic [1:0]            cnt;
    logic [1:0]            resp;
    // grant is combinational so the requester's fields are sampled in the grant cycle itself
    always_comb begin
        win   = (req == 2'b11) ? ~last_winner : req[1];
        gnt   = (rst_n && state == IDLE && |req) ? (win ? 2'b10 : 2'b01) : 2'b00;
        legal = l_we ? (l_f3 <= 3'd2) : (l_f3 <= 3'd2 || l_f3 == 3'd4 || l_f3 == 3'd5);
        resp  = owner ? 2'b10 : 2'b01;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            owner       <= 1'b0;
            l_we        <= 1'b0;
            l_f3        <= '0;
            l_addr      <= '0;
            l_wdata     <= '0;
            cnt         <= '0;
            rvalid      <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_funct3  <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            rvalid    <= '0;
            err       <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    owner       <= win;
                    last_winner <= win;
                    l_we        <= we[win];
                    l_f3        <= win ? funct3_1 : funct3_0;
                    l_addr      <= win ? addr_1 : addr_0;
                    l_wdata     <= win ? wdata_1 : wdata_0;
                    state       <= CHECK;
                end
                CHECK: if (!legal) begin
                    rvalid <= resp;
                    err    <= 1'b1;
                    rdata  <= '0;
                    state  <= RESP;
                end else begin
                    mem_addr   <= l_addr;
                    mem_funct3 <= l_f3;
                    mem_wdata  <= l_wdata;
                    mem_write  <= l_we;
                    mem_read   <= !l_we;
                    state      <= ISSUE;
                end
                ISSUE: if (l_we || RD_LAT == 0) begin
                    if (!l_we) rdata <= mem_rdata;
                    mem_read <= 1'b0;
                    rvalid   <= resp;
                    state    <= RESP;
                end else begin
                    cnt   <= 2'(RD_LAT);
                    state <= WAIT;
                end
                WAIT: if (cnt == 2'd1) begin
                    rdata    <= mem_rdata;
                    mem_read <= 1'b0;
                    rvalid   <= resp;
                    state    <= RESP;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiters (RD_LAT=1 and RD_LAT=0) share one stimulus stream and
// are checked every cycle against a transaction-level model plus directed literal checks.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [2:0]  funct3_0, funct3_1;
    logic [8:0]  addr_0, addr_1;
    logic [31:0] wdata_0, wdata_1;
    logic [1:0]  gnt [2];
    logic [1:0]  rvalid [2];
    logic        err [2];
    logic [31:0] rdata [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [2:0]  mem_funct3 [2];
    logic [8:0]  mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] rdm0, rdm1;
    logic [31:0] bm0 [512];
    logic [31:0] bm1 [512];
    int          chk_id;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .funct3_0(funct3_0), .funct3_1(funct3_1), .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1), .gnt(gnt[0]), .rvalid(rvalid[0]),
        .err(err[0]), .rdata(rdata[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_funct3(mem_funct3[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(rdm0));

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .funct3_0(funct3_0), .funct3_1(funct3_1), .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1), .gnt(gnt[1]), .rvalid(rvalid[1]),
        .err(err[1]), .rdata(rdata[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_funct3(mem_funct3[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(rdm1));

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
        return f == 3'b000 ? {{24{w[7]}}, w[7:0]} : f == 3'b001 ? {{16{w[15]}}, w[15:0]} :
               f == 3'b100 ? {24'b0, w[7:0]} : f == 3'b101 ? {16'b0, w[15:0]} : w;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [2:0] f);
        return f == 3'b000 ? {o[31:8], w[7:0]} : f == 3'b001 ? {o[31:16], w[15:0]} : w;
    endfunction

    function automatic logic legal_op(input logic w, input logic [2:0] f);
        return w ? (f == 3'd0 || f == 3'd1 || f == 3'd2)
                 : (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    endfunction

    // memory 0 is a synchronous SRAM (one cycle read), memory 1 is combinational
    always @(posedge clk) begin
        if (mem_write[0]) bm0[mem_addr[0]] <= merge(bm0[mem_addr[0]], mem_wdata[0], mem_funct3[0]);
        if (mem_write[1]) bm1[mem_addr[1]] <= merge(bm1[mem_addr[1]], mem_wdata[1], mem_funct3[1]);
        rdm0 <= ext(bm0[mem_addr[0]], mem_funct3[0]);
    end
    assign rdm1 = ext(bm1[mem_addr[1]], mem_funct3[1]);

    task automatic ck(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    // model state: one outstanding transaction per arbiter
    logic        busy [2];
    logic        last [2];
    logic        own [2];
    logic        mwe [2];
    logic [2:0]  mf3 [2];
    logic [8:0]  maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] m_rdata [2];
    logic [31:0] mmem [2][512];
    int          t0 [2];
    // observation logs, cleared at every mark
    int          g_cnt [2], g_cyc [2], rv_cnt [2], rv_cyc [2], mw_cnt [2], mr_cnt [2], two_gnt [2];
    logic [1:0]  g_val [2], g_first [2], rv_val [2];
    logic [7:0]  g_seq [2];
    logic        rv_err [2];
    logic [31:0] rv_rdata [2];
    logic [8:0]  mw_addr [2];
    int          d, lat, big_l;
    logic        lg, emw, emr;
    logic [1:0]  eg, erv;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (gnt[i] != 2'b00) begin
                if (g_cnt[i] == 0) g_first[i] = gnt[i];
                g_cnt[i]++;
                g_cyc[i] = cyc;
                g_val[i] = gnt[i];
                g_seq[i] = {g_seq[i][6:0], gnt[i][1]};
                if (gnt[i] == 2'b11) two_gnt[i]++;
            end
            if (rvalid[i] != 2'b00) begin
                rv_cnt[i]++;
                rv_cyc[i] = cyc;
                rv_val[i] = rvalid[i];
                rv_err[i] = err[i];
                rv_rdata[i] = rdata[i];
            end
            if (mem_write[i]) begin
                mw_cnt[i]++;
                mw_addr[i] = mem_addr[i];
            end
            if (mem_read[i]) mr_cnt[i]++;
            if (!rst_n) begin
                ck("reset_ctl", i, 32'({gnt[i], rvalid[i], err[i], mem_read[i], mem_write[i], mem_funct3[i], mem_addr[i]}), 32'd0);
                ck("reset_rdata", i, rdata[i], 32'd0);
                ck("reset_wdata", i, mem_wdata[i], 32'd0);
                busy[i] = 1'b0;
                last[i] = 1'b1;
                m_rdata[i] = 32'd0;
            end else begin
                d = cyc - t0[i];
                lat = (i == 0) ? 1 : 0;
                lg = legal_op(mwe[i], mf3[i]);
                big_l = !lg ? 2 : mwe[i] ? 3 : 3 + lat;
                eg = (busy[i] || req == 2'b00) ? 2'b00 : req == 2'b11 ? (last[i] ? 2'b01 : 2'b10) : req;
                emw = busy[i] && lg && mwe[i] && d == 2;
                emr = busy[i] && lg && !mwe[i] && d >= 2 && d <= 2 + lat;
                erv = (busy[i] && d == big_l) ? (own[i] ? 2'b10 : 2'b01) : 2'b00;
                if (erv != 2'b00)
                    m_rdata[i] = !lg ? 32'd0 : mwe[i] ? m_rdata[i] : ext(mmem[i][maddr[i]], mf3[i]);
                ck("gnt", i, 32'(gnt[i]), 32'(eg));
                ck("rvalid", i, 32'(rvalid[i]), 32'(erv));
                ck("mem_write", i, 32'(mem_write[i]), 32'(emw));
                ck("mem_read", i, 32'(mem_read[i]), 32'(emr));
                if (emw || emr) begin
                    ck("mem_addr", i, 32'(mem_addr[i]), 32'(maddr[i]));
                    ck("mem_funct3", i, 32'(mem_funct3[i]), 32'(mf3[i]));
                end
                if (emw) begin
                    ck("mem_wdata", i, mem_wdata[i], mwd[i]);
                    mmem[i][maddr[i]] = merge(mmem[i][maddr[i]], mwd[i], mf3[i]);
                end
                if (erv != 2'b00) begin
                    ck("err", i, 32'(err[i]), 32'(!lg));
                    ck("rdata", i, rdata[i], m_rdata[i]);
                    busy[i] = 1'b0;
                end else if (eg != 2'b00) begin
                    busy[i] = 1'b1;
                    t0[i] = cyc;
                    own[i] = eg[1];
                    last[i] = eg[1];
                    mwe[i] = we[eg[1]];
                    mf3[i] = eg[1] ? funct3_1 : funct3_0;
                    maddr[i] = eg[1] ? addr_1 : addr_0;
                    mwd[i] = eg[1] ? wdata_1 : wdata_0;
                end
            end
        end
        case (chk_id)
            1: begin
                ck("rst_rvalid", 0, 32'(rvalid[0]), 32'd0);
                ck("rst_strobes", 0, 32'({mem_read[0], mem_write[0]}), 32'd0);
                ck("rst_rdata", 0, rdata[0], 32'd0);
            end
            2: begin
                ck("st_gnt", 0, 32'(g_val[0]), 32'h1);
                ck("st_mw_cycles", 0, 32'(mw_cnt[0]), 32'd1);
                ck("st_mw_addr", 0, 32'(mw_addr[0]), 32'h005);
                ck("st_latency", 0, 32'(rv_cyc[0] - g_cyc[0]), 32'd3);
                ck("st_rvalid", 0, 32'(rv_val[0]), 32'h1);
                ck("st_err", 0, 32'(rv_err[0]), 32'd0);
                ck("st_latency", 1, 32'(rv_cyc[1] - g_cyc[1]), 32'd3);
            end
            3: begin
                ck("ld_gnt", 0, 32'(g_val[0]), 32'h2);
                ck("ld_mr_cycles", 0, 32'(mr_cnt[0]), 32'd2);
                ck("ld_rdata", 0, rv_rdata[0], 32'hDEADBEEF);
                ck("ld_rvalid", 0, 32'(rv_val[0]), 32'h2);
                ck("ld_latency", 0, 32'(rv_cyc[0] - g_cyc[0]), 32'd4);
                ck("ld_latency", 1, 32'(rv_cyc[1] - g_cyc[1]), 32'd3);
                ck("ld_rdata", 1, rv_rdata[1], 32'hDEADBEEF);
            end
            4: begin
                ck("rr_count", 0, 32'(g_cnt[0]), 32'd4);
                ck("rr_order", 0, 32'(g_seq[0]), 32'h05);
                ck("rr_double", 0, 32'(two_gnt[0]), 32'd0);
            end
            5: begin
                ck("ill_mw_cycles", 0, 32'(mw_cnt[0]), 32'd0);
                ck("ill_err", 0, 32'(rv_err[0]), 32'd1);
                ck("ill_rdata", 0, rv_rdata[0], 32'd0);
                ck("ill_rvalid", 0, 32'(rv_val[0]), 32'h1);
                ck("ill_latency", 0, 32'(rv_cyc[0] - g_cyc[0]), 32'd2);
            end
            6: begin
                ck("mid_rst_ctl", 0, 32'({gnt[0], rvalid[0], err[0], mem_read[0], mem_write[0]}), 32'd0);
                ck("mid_rst_addr", 0, 32'(mem_addr[0]), 32'd0);
                ck("mid_rst_rvalid", 1, 32'(rvalid[1]), 32'd0);
            end
            7: begin
                ck("post_rst_rvalid", 0, 32'(rv_cnt[0]), 32'd0);
                ck("post_rst_rvalid", 1, 32'(rv_cnt[1]), 32'd0);
                ck("post_rst_mr", 0, 32'(mr_cnt[0]), 32'd0);
            end
            8: begin
                ck("post_rst_tie", 0, 32'(g_first[0]), 32'h1);
                ck("post_rst_tie", 1, 32'(g_first[1]), 32'h1);
            end
            9: ck("sb_mw_cycles", 0, 32'(mw_cnt[0]), 32'd1);
            10: begin
                ck("lb_rdata", 1, rv_rdata[1], 32'hFFFFFF80);
                ck("lb_latency", 1, 32'(rv_cyc[1] - g_cyc[1]), 32'd3);
                ck("lb_rvalid", 1, 32'(rv_val[1]), 32'h1);
                ck("lb_rdata", 0, rv_rdata[0], 32'hFFFFFF80);
                ck("lb_latency", 0, 32'(rv_cyc[0] - g_cyc[0]), 32'd4);
            end
            default: ;
        endcase
        if (chk_id != 0) begin
            for (int i = 0; i < 2; i++) begin
                g_cnt[i] = 0;
                g_seq[i] = '0;
                rv_cnt[i] = 0;
                mw_cnt[i] = 0;
                mr_cnt[i] = 0;
                two_gnt[i] = 0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input int k);
        chk_id = k;
        tick();
        chk_id = 0;
    endtask

    task automatic idle(input int n);
        req = 2'b00;
        repeat (n) tick();
    endtask

    task automatic issue(input int p, input logic w, input logic [2:0] f, input logic [8:0] a, input logic [31:0] wd);
        if (p == 0) begin
            funct3_0 = f;
            addr_0 = a;
            wdata_0 = wd;
        end else begin
            funct3_1 = f;
            addr_1 = a;
            wdata_1 = wd;
        end
        we[p] = w;
        req = (p == 0) ? 2'b01 : 2'b10;
        tick();
        req = 2'b00;
    endtask

    initial begin
        req = 2'b00;
        we = 2'b00;
        funct3_0 = '0;
        funct3_1 = '0;
        addr_0 = '0;
        addr_1 = '0;
        wdata_0 = '0;
        wdata_1 = '0;
        chk_id = 0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        mark(1);
        rst_n = 1'b1;
        idle(2);
        issue(0, 1'b1, 3'b010, 9'h005, 32'hDEADBEEF);
        idle(6);
        mark(2);
        issue(1, 1'b0, 3'b010, 9'h005, 32'h0);
        idle(6);
        mark(3);
        we = 2'b11;
        funct3_0 = 3'b010;
        funct3_1 = 3'b010;
        addr_0 = 9'h001;
        addr_1 = 9'h002;
        wdata_0 = 32'h11111111;
        wdata_1 = 32'h22222222;
        req = 2'b11;
        repeat (16) tick();
        idle(4);
        mark(4);
        issue(0, 1'b1, 3'b100, 9'h007, 32'hCAFEF00D);
        idle(6);
        mark(5);
        issue(1, 1'b0, 3'b010, 9'h005, 32'h0);
        repeat (2) tick();
        rst_n = 1'b0;
        chk_id = 6;
        tick();
        chk_id = 0;
        tick();
        rst_n = 1'b1;
        idle(6);
        mark(7);
        we = 2'b11;
        funct3_0 = 3'b010;
        funct3_1 = 3'b010;
        req = 2'b11;
        tick();
        idle(6);
        mark(8);
        issue(0, 1'b1, 3'b000, 9'h010, 32'h00000080);
        idle(6);
        mark(9);
        issue(0, 1'b0, 3'b000, 9'h010, 32'h0);
        idle(6);
        mark(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
